// File: rtl/rv_pkg.sv
// Shared constants for the RV32I pipeline registers: datapath widths,
// writeback-select encoding and load/store access sizes.
package rv_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane alignment for a 32-bit data port: replicates store
// data across lanes, builds the byte mask and flags misaligned accesses.
module mem_lane_align
  import rv_pkg::*;
(
  input  logic [1:0]      size,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] rs2,
  output logic [XLEN-1:0] wdata,
  output logic [3:0]      bmask,
  output logic            misaligned
);

  always_comb begin
    wdata      = rs2;
    bmask      = 4'b0000;
    misaligned = 1'b0;
    case (size)
      SZ_B: begin
        wdata = {4{rs2[7:0]}};
        bmask = 4'b0001 << addr_lo;
      end
      SZ_H: begin
        wdata      = {2{rs2[15:0]}};
        bmask      = 4'b0011 << {addr_lo[1], 1'b0};
        misaligned = addr_lo[0];
      end
      SZ_W: begin
        bmask      = 4'b1111;
        misaligned = |addr_lo;
      end
      // size 11 has no legal encoding: no lanes, always a fault
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: captures the execute result with pre-aligned
// store lanes and drives the EX->ID forwarding bus from registered state.
module ex_mem_reg #(
  parameter int XLEN   = rv_pkg::XLEN,
  parameter int REG_AW = rv_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [XLEN-1:0]   ex_alu_result,
  input  logic [XLEN-1:0]   ex_rs2_data,
  input  logic [XLEN-1:0]   ex_pc_plus4,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_wen,
  input  logic              ex_mem_ren,
  input  logic              ex_mem_wen,
  input  logic [2:0]        ex_funct3,
  input  logic [1:0]        ex_wb_sel,
  input  logic              stall,
  input  logic              flush,
  output logic              mem_valid,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [3:0]        mem_bmask,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic              mem_misaligned,
  output logic [REG_AW-1:0] mem_rd,
  output logic              mem_reg_wen,
  output logic [2:0]        mem_funct3,
  output logic [1:0]        mem_wb_sel,
  output logic [XLEN-1:0]   mem_pc_plus4,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_rd,
  output logic [XLEN-1:0]   fwd_data
);
  import rv_pkg::*;

  logic [XLEN-1:0] al_wdata;
  logic [3:0]      al_bmask;
  logic            al_mis;
  logic            fault;

  mem_lane_align u_align (
    .size       (ex_funct3[1:0]),
    .addr_lo    (ex_alu_result[1:0]),
    .rs2        (ex_rs2_data),
    .wdata      (al_wdata),
    .bmask      (al_bmask),
    .misaligned (al_mis)
  );

  // Only real memory accesses can fault; ALU ops ignore the size decode.
  assign fault = ex_valid & (ex_mem_ren | ex_mem_wen) & al_mis;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid      <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_bmask      <= '0;
      mem_ren        <= 1'b0;
      mem_wen        <= 1'b0;
      mem_misaligned <= 1'b0;
      mem_rd         <= '0;
      mem_reg_wen    <= 1'b0;
      mem_funct3     <= '0;
      mem_wb_sel     <= '0;
      mem_pc_plus4   <= '0;
    end else if (flush) begin
      mem_valid      <= 1'b0;
      mem_ren        <= 1'b0;
      mem_wen        <= 1'b0;
      mem_reg_wen    <= 1'b0;
      mem_misaligned <= 1'b0;
    end else if (!stall) begin
      mem_valid      <= ex_valid;
      mem_addr       <= ex_alu_result;
      mem_wdata      <= al_wdata;
      mem_bmask      <= al_bmask;
      mem_ren        <= ex_valid & ex_mem_ren & ~fault;
      mem_wen        <= ex_valid & ex_mem_wen & ~fault;
      mem_misaligned <= fault;
      mem_rd         <= ex_rd;
      mem_reg_wen    <= ex_valid & ex_reg_wen & (|ex_rd) & ~fault;
      mem_funct3     <= ex_funct3;
      mem_wb_sel     <= ex_wb_sel;
      mem_pc_plus4   <= ex_pc_plus4;
    end
  end

  // Load data is not available until MEM completes, so loads never forward.
  assign fwd_valid = mem_valid & mem_reg_wen & ~mem_ren;
  assign fwd_rd    = mem_rd;
  assign fwd_data  = (mem_wb_sel == WB_PC4) ? mem_pc_plus4 : mem_addr;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Randomized and directed bench for ex_mem_reg against an arithmetic
// reference model of the EX/MEM register behaviour.
module tb_ex_mem_reg;
  import rv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [31:0] ex_alu_result, ex_rs2_data, ex_pc_plus4;
  logic [4:0]  ex_rd;
  logic        ex_reg_wen, ex_mem_ren, ex_mem_wen;
  logic [2:0]  ex_funct3;
  logic [1:0]  ex_wb_sel;
  logic        stall, flush;
  logic        mem_valid, mem_ren, mem_wen, mem_misaligned, mem_reg_wen;
  logic [31:0] mem_addr, mem_wdata, mem_pc_plus4, fwd_data;
  logic [3:0]  mem_bmask;
  logic [4:0]  mem_rd, fwd_rd;
  logic [2:0]  mem_funct3;
  logic [1:0]  mem_wb_sel;
  logic        fwd_valid;

  int n_chk = 0;
  int n_fail = 0;

  // reference model state
  logic        e_valid, e_ren, e_wen, e_mis, e_rwen, e_wd_ok;
  logic [31:0] e_addr, e_wdata, e_pc4;
  logic [3:0]  e_bmask;
  logic [4:0]  e_rd;
  logic [2:0]  e_f3;
  logic [1:0]  e_wb;

  ex_mem_reg dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_alu_result(ex_alu_result),
    .ex_rs2_data(ex_rs2_data), .ex_pc_plus4(ex_pc_plus4), .ex_rd(ex_rd),
    .ex_reg_wen(ex_reg_wen), .ex_mem_ren(ex_mem_ren), .ex_mem_wen(ex_mem_wen),
    .ex_funct3(ex_funct3), .ex_wb_sel(ex_wb_sel), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_bmask(mem_bmask), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .mem_misaligned(mem_misaligned), .mem_rd(mem_rd), .mem_reg_wen(mem_reg_wen),
    .mem_funct3(mem_funct3), .mem_wb_sel(mem_wb_sel), .mem_pc_plus4(mem_pc_plus4),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    e_valid = 0; e_ren = 0; e_wen = 0; e_mis = 0; e_rwen = 0; e_wd_ok = 1;
    e_addr = 0; e_wdata = 0; e_pc4 = 0; e_bmask = 0; e_rd = 0; e_f3 = 0; e_wb = 0;
  endtask

  task automatic model_edge();
    int sz, a;
    logic bad, acc;
    if (flush) begin
      e_valid = 0; e_ren = 0; e_wen = 0; e_rwen = 0; e_mis = 0;
    end else if (!stall) begin
      sz = int'(ex_funct3) % 4;
      a  = int'(ex_alu_result % 4);
      e_wd_ok = 1;
      case (sz)
        0: begin e_bmask = 4'(1 << a); e_wdata = {24'h0, ex_rs2_data[7:0]} * 32'h01010101; bad = 0; end
        1: begin e_bmask = 4'(3 << (a / 2 * 2)); e_wdata = {16'h0, ex_rs2_data[15:0]} * 32'h00010001; bad = (a % 2) != 0; end
        2: begin e_bmask = 4'hF; e_wdata = ex_rs2_data; bad = a != 0; end
        default: begin e_bmask = 4'h0; e_wd_ok = 0; bad = 1; end
      endcase
      acc     = ex_valid && (ex_mem_ren || ex_mem_wen);
      e_mis   = acc && bad;
      e_valid = ex_valid;
      e_ren   = ex_valid && ex_mem_ren && !e_mis;
      e_wen   = ex_valid && ex_mem_wen && !e_mis;
      e_rwen  = ex_valid && ex_reg_wen && (ex_rd != 0) && !e_mis;
      e_addr  = ex_alu_result; e_pc4 = ex_pc_plus4; e_rd = ex_rd;
      e_f3    = ex_funct3; e_wb = ex_wb_sel;
    end
  endtask

  task automatic check_all(input string p);
    chk({p, ".valid"}, 32'(mem_valid), 32'(e_valid));
    chk({p, ".addr"}, mem_addr, e_addr);
    if (e_wd_ok) chk({p, ".wdata"}, mem_wdata, e_wdata);
    chk({p, ".bmask"}, 32'(mem_bmask), 32'(e_bmask));
    chk({p, ".ren"}, 32'(mem_ren), 32'(e_ren));
    chk({p, ".wen"}, 32'(mem_wen), 32'(e_wen));
    chk({p, ".mis"}, 32'(mem_misaligned), 32'(e_mis));
    chk({p, ".rd"}, 32'(mem_rd), 32'(e_rd));
    chk({p, ".rwen"}, 32'(mem_reg_wen), 32'(e_rwen));
    chk({p, ".f3"}, 32'(mem_funct3), 32'(e_f3));
    chk({p, ".wb"}, 32'(mem_wb_sel), 32'(e_wb));
    chk({p, ".pc4"}, mem_pc_plus4, e_pc4);
    chk({p, ".fwd_v"}, 32'(fwd_valid), 32'(e_valid && e_rwen && !e_ren));
    chk({p, ".fwd_rd"}, 32'(fwd_rd), 32'(e_rd));
    chk({p, ".fwd_d"}, fwd_data, (e_wb == WB_PC4) ? e_pc4 : e_addr);
  endtask

  task automatic cycle(input string p);
    @(posedge clk);
    model_edge();
    #1;
    check_all(p);
  endtask

  task automatic set_in(input logic v, input logic [31:0] alu, input logic [31:0] rs2,
                        input logic [31:0] pc4, input logic [4:0] rd, input logic rwen,
                        input logic ren, input logic wen, input logic [2:0] f3,
                        input logic [1:0] wb);
    ex_valid = v; ex_alu_result = alu; ex_rs2_data = rs2; ex_pc_plus4 = pc4;
    ex_rd = rd; ex_reg_wen = rwen; ex_mem_ren = ren; ex_mem_wen = wen;
    ex_funct3 = f3; ex_wb_sel = wb;
  endtask

  task automatic set_rand();
    set_in($urandom_range(0, 4) != 0, $urandom, $urandom, $urandom, 5'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), 2'($urandom));
  endtask

  logic [31:0] snap_addr;

  initial begin
    rst_n = 0; stall = 0; flush = 0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #2;
    check_all("reset");
    #10 rst_n = 1;

    // SW to rd=0
    set_in(1, 32'h1000, 32'hDEADBEEF, 32'h4, 0, 1, 0, 1, 3'b010, WB_ALU);
    cycle("sw");
    chk("sw_wen", 32'(mem_wen), 1);
    chk("sw_bmask", 32'(mem_bmask), 32'hF);
    chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
    chk("sw_rwen", 32'(mem_reg_wen), 0);

    set_in(1, 32'h1003, 32'h000000A5, 32'h8, 0, 0, 0, 1, 3'b000, WB_ALU);
    cycle("sb");
    chk("sb_bmask", 32'(mem_bmask), 32'h8);
    chk("sb_wdata", mem_wdata, 32'hA5A5A5A5);
    chk("sb_mis", 32'(mem_misaligned), 0);

    set_in(1, 32'h2001, 32'h0, 32'hC, 5, 1, 1, 0, 3'b001, WB_MEM);
    cycle("lh_mis");
    chk("lh_mis", 32'(mem_misaligned), 1);
    chk("lh_ren", 32'(mem_ren), 0);
    chk("lh_rwen", 32'(mem_reg_wen), 0);

    set_in(1, 32'h2002, 32'h1234, 32'h10, 0, 0, 0, 1, 3'b001, WB_ALU);
    cycle("sh");
    chk("sh_bmask", 32'(mem_bmask), 32'hC);
    chk("sh_mis", 32'(mem_misaligned), 0);

    set_in(1, 32'h200, 32'h0, 32'h84, 1, 1, 0, 0, 3'b000, WB_PC4);
    cycle("jal");
    chk("jal_fwd_v", 32'(fwd_valid), 1);
    chk("jal_fwd_rd", 32'(fwd_rd), 1);
    chk("jal_fwd_d", fwd_data, 32'h84);

    set_in(1, 32'h200, 32'h0, 32'h84, 1, 1, 1, 0, 3'b010, WB_MEM);
    cycle("ld_nofwd");
    chk("ld_fwd_v", 32'(fwd_valid), 0);

    // ADD then a 3-cycle stall with churning EX inputs, then stall+flush
    set_in(1, 32'h1234, 32'h5, 32'h20, 3, 1, 0, 0, 3'b000, WB_ALU);
    cycle("add");
    snap_addr = 32'h1234;
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      set_rand();
      cycle("stall");
      chk("stall_addr", mem_addr, snap_addr);
      chk("stall_valid", 32'(mem_valid), 1);
    end
    flush = 1;
    cycle("stflush");
    chk("stflush_valid", 32'(mem_valid), 0);
    chk("stflush_addr", mem_addr, snap_addr);
    stall = 0; flush = 0;

    // asynchronous reset between edges, then capture on the first edge
    set_in(1, 32'h300, 32'h0, 32'h90, 7, 1, 0, 0, 3'b000, WB_ALU);
    cycle("pre_rst");
    #2 rst_n = 0;
    model_reset();
    #1;
    check_all("async_rst");
    chk("async_rst_valid", 32'(mem_valid), 0);
    #1 rst_n = 1;
    set_in(1, 32'h404, 32'h0, 32'h94, 9, 1, 0, 0, 3'b000, WB_ALU);
    cycle("post_rst");
    chk("post_rst_addr", mem_addr, 32'h404);
    chk("post_rst_fwd_v", 32'(fwd_valid), 1);

    for (int i = 0; i < 400; i++) begin
      set_rand();
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 9) == 0);
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_mem_reg.md
# ex_mem_reg

EX/MEM pipeline register of the 5-stage RV32I pipeline. It captures the execute-stage result, which is the ALU/shifter output used as the data address or writeback value, along with the store operand and control bits. It pre-computes the byte-lane alignment and byte mask for the MEM stage and flags misaligned accesses. It also drives the EX→ID forwarding bus from its registered contents. Stall and flush are driven by the hazard unit.

## Interface
- XLEN, 32, datapath width
- REG_AW, 5, register-index width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- ex_valid  in  1  EX holds a real instruction
- ex_alu_result  in  XLEN  ALU/shifter result (address for load/store)
- ex_rs2_data  in  XLEN  store operand
- ex_pc_plus4  in  XLEN  link value for JAL/JALR
- ex_rd  in  REG_AW  destination register
- ex_reg_wen  in  1  writes rd
- ex_mem_ren / ex_mem_wen  in  1 each  load / store
- ex_funct3  in  3  access size/sign (RV32I load/store encoding)
- ex_wb_sel  in  2  00 ALU, 01 MEM, 10 PC+4, 11 reserved (treated as ALU)
- stall  in  1  hold all registers
- flush  in  1  insert bubble
- mem_valid  out  1
- mem_addr  out  XLEN  registered ex_alu_result
- mem_wdata  out  XLEN  lane-replicated store data
- mem_bmask  out  4  active byte lanes
- mem_ren / mem_wen  out  1 each  gated by misalignment
- mem_misaligned  out  1  access fault flag
- mem_rd, mem_reg_wen, mem_funct3, mem_wb_sel, mem_pc_plus4  out  registered copies
- fwd_valid  out  1  forwarding data usable
- fwd_rd  out  REG_AW
- fwd_data  out  XLEN

## Operation
- Register update priority on each edge is flush > stall > load.
  - flush=1: mem_valid, mem_ren, mem_wen, mem_reg_wen and mem_misaligned are set to 0. The data registers hold.
  - stall=1 with flush=0: every register holds.
  - Otherwise the register loads from EX. If ex_valid=0, the load is a bubble: all control bits are 0.
- ex_rd==0 forces mem_reg_wen=0 at capture.
- Size is decoded from funct3[1:0]; funct3[2] (unsigned) is carried through untouched.
  - 00 (byte): wdata={4{rs2[7:0]}}, bmask=4'b0001<<addr[1:0]
  - 01 (half): wdata={2{rs2[15:0]}}, bmask=4'b0011<<{addr[1],1'b0}; misaligned if addr[0]
  - 10 (word): wdata=rs2, bmask=4'b1111; misaligned if addr[1:0]!=0
  - 11 (illegal): bmask=0, misaligned=1
- mem_misaligned is captured only when ex_valid and (ex_mem_ren|ex_mem_wen). When it is set, mem_ren, mem_wen and mem_reg_wen are all forced to 0.
- The bmask/wdata computation applies to every instruction. The MEM stage ignores it unless mem_ren or mem_wen is set.
- Forwarding:
  - fwd_valid = mem_valid & mem_reg_wen & ~mem_ren. Loads never forward from this stage.
  - fwd_data = mem_pc_plus4 when mem_wb_sel==10, else mem_addr.
  - fwd_rd = mem_rd.

## Timing
- Latency is 1 cycle from EX input to every mem_* output.
- Every mem_* output comes straight from a flop. fwd_* is combinational from flops only.
- There is no combinational path from any input to any output.
- Asynchronous reset clears every register to 0, so all outputs read 0 with fwd_valid=0.
- Reset asserted mid-stall or mid-flush wins immediately. The first edge after deassertion loads normally.
- Holding stall for N cycles keeps all outputs constant for N cycles.
- flush and stall asserted in the same cycle produce a bubble.

## Structure
- Shared package `rv_pkg` holds:
  - the wb_sel encoding constants (WB_ALU, WB_MEM, WB_PC4)
  - the size constants (SZ_B, SZ_H, SZ_W)
  - XLEN/REG_AW defaults shared with the other pipeline registers
- One combinational sub-module, `mem_lane_align`, maps (funct3, addr[1:0], rs2) to (wdata, bmask, misaligned). ex_mem_reg registers its outputs.
- Everything else is flat registers plus update-priority logic.

## Test plan
- SW: addr=0x1000, rs2=0xDEADBEEF, rd=0, reg_wen=1. Next cycle: mem_wen=1, bmask=1111, wdata=0xDEADBEEF, mem_reg_wen=0.
- SB: addr=0x1003, rs2=0x000000A5. Next cycle: bmask=1000, wdata=0xA5A5A5A5, misaligned=0.
- LH: addr=0x2001. Next cycle: misaligned=1 and mem_ren=mem_reg_wen=0. An SH at addr=0x2002 instead gives bmask=1100 with no fault.
- JAL: rd=1, wb_sel=10, pc_plus4=0x84, alu_result=0x200. Next cycle: fwd_valid=1, fwd_rd=1, fwd_data=0x84. The same case with wb_sel=01 and mem_ren=1 gives fwd_valid=0.
- Load a valid ADD, then assert stall 3 cycles with changing EX inputs: outputs stay constant. Then assert stall=flush=1: the next cycle shows mem_valid=0 with mem_addr unchanged.
- With a valid instruction registered, pulse rst_n low between edges: outputs go to 0 immediately with no clock. The first edge after release captures the EX inputs.
